// File: rtl/v850_seq_ctrl.sv
// Multi-cycle V850 instruction sequencer: owns the PC and walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB, applying branches and EI-level exceptions.
module v850_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             dec_valid,
  output logic [31:0]      inst_o,
  input  logic             dec_len32,
  input  logic             dec_mem,
  output logic             ex_en,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  output logic             mem_en,
  input  logic             mem_done,
  output logic             wb_en,
  input  logic             exc_req,
  input  logic [31:0]      exc_vector,
  output logic             exc_ack,
  output logic [31:0]      eipc_o,
  output logic [31:0]      pc,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t      state;
  logic        len32_q;
  logic        mem_q;
  logic [31:0] next_pc;

  // The PC space is 26 bits wide: bit 25 sign-extends into the top bits and bit 0 is always clear.
  function automatic logic [31:0] canon(input logic [31:0] x);
    return {{6{x[25]}}, x[25:1], 1'b0};
  endfunction

  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= canon(RESET_PC);
      inst_o    <= '0;
      eipc_o    <= '0;
      instret   <= '0;
      next_pc   <= '0;
      len32_q   <= 1'b0;
      mem_q     <= 1'b0;
      imem_req  <= 1'b0;
      dec_valid <= 1'b0;
      ex_en     <= 1'b0;
      mem_en    <= 1'b0;
      wb_en     <= 1'b0;
      exc_ack   <= 1'b0;
    end else begin
      exc_ack <= 1'b0;
      case (state)
        // Request is raised on entry; an ack is honoured only while the request is visible.
        S_FETCH: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            inst_o    <= imem_rdata;
            imem_req  <= 1'b0;
            dec_valid <= 1'b1;
            state     <= S_DECODE;
          end
        end
        S_DECODE: begin
          len32_q   <= dec_len32;
          mem_q     <= dec_mem;
          dec_valid <= 1'b0;
          ex_en     <= 1'b1;
          state     <= S_EXEC;
        end
        S_EXEC: begin
          ex_en   <= 1'b0;
          next_pc <= br_taken ? br_target : (pc + (len32_q ? 32'd4 : 32'd2));
          if (mem_q) begin
            mem_en <= 1'b1;
            state  <= S_MEM;
          end else begin
            wb_en <= 1'b1;
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_done) begin
            mem_en <= 1'b0;
            wb_en  <= 1'b1;
            state  <= S_WB;
          end
        end
        // Retire always completes; a pending exception only changes where the next fetch goes.
        S_WB: begin
          wb_en    <= 1'b0;
          instret  <= instret + CNT_W'(1);
          imem_req <= 1'b1;
          state    <= S_FETCH;
          if (exc_req) begin
            eipc_o  <= canon(next_pc);
            pc      <= canon(exc_vector);
            exc_ack <= 1'b1;
          end else begin
            pc <= canon(next_pc);
          end
        end
        default: begin
          state     <= S_FETCH;
          imem_req  <= 1'b0;
          dec_valid <= 1'b0;
          ex_en     <= 1'b0;
          mem_en    <= 1'b0;
          wb_en     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_v850_seq_ctrl.sv
// Scoreboard bench for v850_seq_ctrl: directed instruction vectors push expected
// fetch/retire/exception records; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_v850_seq_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        dec_valid, dec_len32 = 1'b0, dec_mem = 1'b0;
  logic [31:0] inst_o;
  logic        ex_en, br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        mem_en, mem_done = 1'b0, wb_en;
  logic        exc_req = 1'b0, exc_ack;
  logic [31:0] exc_vector = '0, eipc_o, pc;
  logic [31:0] instret;

  v850_seq_ctrl #(.RESET_PC(32'h0000_0100), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dec_valid(dec_valid), .inst_o(inst_o), .dec_len32(dec_len32), .dec_mem(dec_mem),
    .ex_en(ex_en), .br_taken(br_taken), .br_target(br_target),
    .mem_en(mem_en), .mem_done(mem_done), .wb_en(wb_en),
    .exc_req(exc_req), .exc_vector(exc_vector), .exc_ack(exc_ack), .eipc_o(eipc_o),
    .pc(pc), .instret(instret)
  );

  // Free-running instance with a 3-bit counter to exercise counter wrap.
  logic        rst_w = 1'b1;
  logic        w_imem_req, w_dec_valid, w_ex_en, w_mem_en, w_wb_en, w_exc_ack;
  logic [31:0] w_imem_addr, w_inst_o, w_eipc_o, w_pc;
  logic [2:0]  w_instret;

  v850_seq_ctrl #(.RESET_PC(32'h0), .CNT_W(3)) dut_wrap (
    .clk(clk), .rst(rst_w),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(1'b1), .imem_rdata(32'h0),
    .dec_valid(w_dec_valid), .inst_o(w_inst_o), .dec_len32(1'b0), .dec_mem(1'b0),
    .ex_en(w_ex_en), .br_taken(1'b0), .br_target(32'h0),
    .mem_en(w_mem_en), .mem_done(1'b0), .wb_en(w_wb_en),
    .exc_req(1'b0), .exc_vector(32'h0), .exc_ack(w_exc_ack), .eipc_o(w_eipc_o),
    .pc(w_pc), .instret(w_instret)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] addr, word;
    int          ack_dly;
    bit          len32, mem;
    int          mem_wait;
    bit          br;
    logic [31:0] tgt;
    bit          exc;
    logic [31:0] vec, exp_pc, exp_eipc;
    int          exp_cyc;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] addr, word, input int dly, input bit l32, m,
                              input int mw, input bit br, input logic [31:0] tgt, input bit exc,
                              input logic [31:0] vec, epc, eipc, input int ecyc);
    vec_t v;
    v.addr = addr; v.word = word; v.ack_dly = dly; v.len32 = l32; v.mem = m; v.mem_wait = mw;
    v.br = br; v.tgt = tgt; v.exc = exc; v.vec = vec; v.exp_pc = epc; v.exp_eipc = eipc;
    v.exp_cyc = ecyc;
    return v;
  endfunction

  logic [31:0] q_fetch[$];
  logic [63:0] q_ret[$];
  logic [63:0] q_exc[$];

  // Monitor: samples 1ns after the falling edge, after the stimulus has settled.
  logic        prev_wb = 1'b0;
  logic [63:0] mon_e;
  int          nstb;
  always begin
    @(negedge clk);
    #1;
    nstb = int'(dec_valid) + int'(ex_en) + int'(wb_en) + int'(exc_ack);
    if (nstb > 0) chk("strobe_overlap", 32'(nstb > 1), 32'd0);
    if (imem_req && imem_ack) begin
      if (q_fetch.size() == 0) chk("fetch_unexpected", 32'd1, 32'd0);
      else chk("fetch_addr", imem_addr, q_fetch.pop_front());
    end
    if (prev_wb && !rst) begin
      if (q_ret.size() == 0) chk("retire_unexpected", 32'd1, 32'd0);
      else begin
        mon_e = q_ret.pop_front();
        chk("retire_pc", pc, mon_e[63:32]);
        chk("retire_instret", instret, mon_e[31:0]);
      end
    end
    if (exc_ack) begin
      if (q_exc.size() == 0) chk("exc_unexpected", 32'd1, 32'd0);
      else begin
        mon_e = q_exc.pop_front();
        chk("exc_eipc", eipc_o, mon_e[63:32]);
        chk("exc_pc", pc, mon_e[31:0]);
      end
    end
    prev_wb <= wb_en;
  end

  // Wrap instance monitor: retirement k must leave instret = k mod 8.
  logic w_prev_wb = 1'b0;
  int   w_n = 0;
  always begin
    @(negedge clk);
    #1;
    if (w_prev_wb) begin
      if (w_n >= 6 && w_n <= 8) chk("wrap_instret", 32'(w_instret), 32'((w_n + 1) % 8));
      w_n <= w_n + 1;
    end
    w_prev_wb <= w_wb_en;
  end

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_instr(input vec_t v, input int exp_cnt);
    bit ok;
    int t0;
    wait_req(ok);
    chk("req_seen", 32'(ok), 32'd1);
    if (!ok) return;
    t0 = cyc;
    q_fetch.push_back(v.addr);
    q_ret.push_back({v.exp_pc, 32'(exp_cnt)});
    if (v.exc) q_exc.push_back({v.exp_eipc, v.exp_pc});
    for (int i = 0; i < v.ack_dly; i++) begin
      chk("req_held", 32'(imem_req), 32'd1);
      chk("addr_stable", imem_addr, v.addr);
      @(negedge clk);
    end
    imem_ack = 1'b1; imem_rdata = v.word;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = '0;
    chk("dec_valid", 32'(dec_valid), 32'd1);
    chk("req_drop", 32'(imem_req), 32'd0);
    chk("inst_o", inst_o, v.word);
    dec_len32 = v.len32; dec_mem = v.mem; exc_req = v.exc; exc_vector = v.vec;
    @(negedge clk);
    dec_len32 = 1'b0; dec_mem = 1'b0;
    chk("ex_en", 32'(ex_en), 32'd1);
    br_taken = v.br; br_target = v.tgt;
    @(negedge clk);
    br_taken = 1'b0; br_target = '0;
    if (v.mem) begin
      for (int i = 0; i <= v.mem_wait; i++) begin
        chk("mem_en", 32'(mem_en), 32'd1);
        chk("wb_early", 32'(wb_en), 32'd0);
        if (i == v.mem_wait) mem_done = 1'b1;
        @(negedge clk);
      end
      mem_done = 1'b0;
      chk("mem_en_drop", 32'(mem_en), 32'd0);
    end
    chk("wb_en", 32'(wb_en), 32'd1);
    @(negedge clk);
    exc_req = 1'b0;
    chk("instr_cycles", 32'(cyc - t0), 32'(v.exp_cyc));
  endtask

  vec_t vecs[12];
  bit   okr;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_w = 1'b1;
    repeat (3) @(negedge clk);
    chk("w_req_in_reset", 32'(w_imem_req), 32'd0);
    rst_w = 1'b0;
    @(negedge clk);
    chk("w_req_first", 32'(w_imem_req), 32'd1);
  end

  initial begin
    //          addr          word          dly l32 mem mw br tgt           exc vec           exp_pc        exp_eipc     cyc
    vecs[0]  = mk(32'h0000_0100, 32'hC0DE_0000, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0102, 32'h0,       4);
    vecs[1]  = mk(32'h0000_0102, 32'hC0DE_0001, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0104, 32'h0,       4);
    vecs[2]  = mk(32'h0000_0104, 32'hC0DE_0002, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0106, 32'h0,       4);
    vecs[3]  = mk(32'h0000_0106, 32'hC0DE_0003, 3, 1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0000_010A, 32'h0,       7);
    vecs[4]  = mk(32'h0000_010A, 32'hC0DE_0004, 0, 0, 0, 0, 1, 32'h0300_0011, 0, 32'h0,         32'hFF00_0010, 32'h0,       4);
    vecs[5]  = mk(32'hFF00_0010, 32'hC0DE_0005, 0, 0, 1, 2, 0, 32'h0,         0, 32'h0,         32'hFF00_0012, 32'h0,       7);
    vecs[6]  = mk(32'hFF00_0012, 32'hC0DE_0006, 0, 0, 0, 0, 1, 32'h01FF_FFFE, 0, 32'h0,         32'h01FF_FFFE, 32'h0,       4);
    vecs[7]  = mk(32'h01FF_FFFE, 32'hC0DE_0007, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         32'hFE00_0000, 32'h0,       4);
    vecs[8]  = mk(32'hFE00_0000, 32'hC0DE_0008, 0, 0, 0, 0, 1, 32'h0000_0200, 0, 32'h0,         32'h0000_0200, 32'h0,       4);
    vecs[9]  = mk(32'h0000_0200, 32'hC0DE_0009, 0, 0, 0, 0, 0, 32'h0,         1, 32'h0000_0080, 32'h0000_0080, 32'h0000_0202, 4);
    vecs[10] = mk(32'h0000_0080, 32'hC0DE_000A, 0, 1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0084, 32'h0,       5);
    vecs[11] = mk(32'h0000_0084, 32'hC0DE_000B, 1, 0, 1, 1, 0, 32'h0,         1, 32'h0000_0123, 32'h0000_0122, 32'h0000_0086, 7);

    repeat (2) @(negedge clk);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_ex_en", 32'(ex_en), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_exc_ack", 32'(exc_ack), 32'd0);
    chk("rst_pc", pc, 32'h0000_0100);
    chk("rst_instret", instret, 32'd0);
    chk("rst_inst_o", inst_o, 32'd0);
    chk("rst_eipc", eipc_o, 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 12; k++) run_instr(vecs[k], k + 1);

    // Reset asserted while a data-memory access is outstanding.
    wait_req(okr);
    chk("abort_req_seen", 32'(okr), 32'd1);
    q_fetch.push_back(32'h0000_0122);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_0001;
    @(negedge clk);
    imem_ack = 1'b0; dec_mem = 1'b1;
    @(negedge clk);
    dec_mem = 1'b0;
    @(negedge clk);
    chk("abort_mem_en_before", 32'(mem_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_mem_en", 32'(mem_en), 32'd0);
    chk("abort_wb_en", 32'(wb_en), 32'd0);
    chk("abort_pc", pc, 32'h0000_0100);
    chk("abort_instret", instret, 32'd0);
    @(negedge clk);
    mem_done = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("late_done_wb", 32'(wb_en), 32'd0);
    chk("late_done_mem_en", 32'(mem_en), 32'd0);
    chk("late_done_req", 32'(imem_req), 32'd1);
    mem_done = 1'b0;
    run_instr(vecs[0], 1);

    repeat (2) @(negedge clk);
    chk("fetch_queue_drained", 32'(q_fetch.size()), 32'd0);
    chk("retire_queue_drained", 32'(q_ret.size()), 32'd0);
    chk("exc_queue_drained", 32'(q_exc.size()), 32'd0);
    chk("wrap_progress", 32'(w_n >= 9), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
